// File: rtl/sensors_intf_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sensors_intf_mem_arbiter
// Description : Two-port Avalon-MM arbiter in front of the single-port sensor
//               interface on-chip RAM. Port A (CPU) and port B (capture DMA)
//               share the RAM with a bounded-burst round-robin policy.
//               Out-of-range accesses are absorbed locally and never reach
//               the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sensors_intf_mem_arbiter #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DEPTH     = 10500,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    // Port A: CPU data master
    input  logic [ADDR_W-1:0] a_address,
    input  logic [3:0]        a_byteenable,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [31:0]       a_writedata,
    output logic              a_waitrequest,
    output logic [31:0]       a_readdata,
    output logic              a_readdatavalid,
    // Port B: sensor capture / DMA engine
    input  logic [ADDR_W-1:0] b_address,
    input  logic [3:0]        b_byteenable,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [31:0]       b_writedata,
    output logic              b_waitrequest,
    output logic [31:0]       b_readdata,
    output logic              b_readdatavalid,
    // Memory s1 slave
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata
);

    localparam logic [7:0]      c_max_burst = MAX_BURST[7:0];
    localparam logic [ADDR_W:0] c_depth     = DEPTH[ADDR_W:0];

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    owner_t              r_owner;
    logic [7:0]          r_run;
    logic                r_rd_a;
    logic                r_rd_b;
    logic                r_rd_oor;

    logic                w_req_a;
    logic                w_req_b;
    logic                w_gnt_a;
    logic                w_gnt_b;
    logic                w_grant;
    owner_t              w_win;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [3:0]          w_mem_be;
    logic [31:0]         w_mem_wdata;
    logic                w_win_write;
    logic                w_win_read;
    logic                w_in_range;

    assign w_req_a = a_read | a_write;
    assign w_req_b = b_read | b_write;

    // Winner selection: owner keeps the RAM until its burst budget runs out
    // while the other port is waiting; grants are suppressed during reset.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!reset) begin
            if (w_req_a && w_req_b) begin
                if (r_run < c_max_burst) begin
                    w_gnt_a = (r_owner == OWN_A);
                    w_gnt_b = (r_owner == OWN_B);
                end else begin
                    w_gnt_a = (r_owner == OWN_B);
                    w_gnt_b = (r_owner == OWN_A);
                end
            end else begin
                w_gnt_a = w_req_a;
                w_gnt_b = w_req_b;
            end
        end
    end

    assign w_grant = w_gnt_a | w_gnt_b;
    assign w_win   = w_gnt_b ? OWN_B : OWN_A;

    // Request mux of the winning port; everything is zero with no grant.
    // Read+write together counts as a write, so the read qualifier excludes it.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_be    = '0;
        w_mem_wdata = '0;
        w_win_write = 1'b0;
        w_win_read  = 1'b0;
        if (w_gnt_a) begin
            w_mem_addr  = a_address;
            w_mem_be    = a_byteenable;
            w_mem_wdata = a_writedata;
            w_win_write = a_write;
            w_win_read  = a_read & ~a_write;
        end else if (w_gnt_b) begin
            w_mem_addr  = b_address;
            w_mem_be    = b_byteenable;
            w_mem_wdata = b_writedata;
            w_win_write = b_write;
            w_win_read  = b_read & ~b_write;
        end
    end

    assign w_in_range     = ({1'b0, w_mem_addr} < c_depth);

    assign mem_address    = w_mem_addr;
    assign mem_byteenable = w_mem_be;
    assign mem_writedata  = w_mem_wdata;
    assign mem_chipselect = w_grant & w_in_range;
    assign mem_write      = mem_chipselect & w_win_write;
    assign mem_clken      = ~reset;

    assign a_waitrequest  = w_req_a & ~w_gnt_a;
    assign b_waitrequest  = w_req_b & ~w_gnt_b;

    // Ownership and consecutive-grant counter (saturating at 255).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWN_A;
            r_run   <= 8'd0;
        end else if (!w_grant) begin
            r_run   <= 8'd0;
        end else if (w_win == r_owner) begin
            if (r_run != 8'hFF) begin
                r_run <= r_run + 8'd1;
            end
        end else begin
            r_owner <= w_win;
            r_run   <= 8'd1;
        end
    end

    // Read-return tags: remember which port read last cycle and whether the
    // read was out of range so its data can be forced to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_a   <= 1'b0;
            r_rd_b   <= 1'b0;
            r_rd_oor <= 1'b0;
        end else begin
            r_rd_a   <= w_gnt_a & a_read & ~a_write;
            r_rd_b   <= w_gnt_b & b_read & ~b_write;
            r_rd_oor <= w_win_read & ~w_in_range;
        end
    end

    // A reset arriving the cycle after a read accept cancels that pulse.
    assign a_readdatavalid = r_rd_a & ~reset;
    assign b_readdatavalid = r_rd_b & ~reset;
    assign a_readdata      = (a_readdatavalid && !r_rd_oor) ? mem_readdata : 32'h0;
    assign b_readdata      = (b_readdatavalid && !r_rd_oor) ? mem_readdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_sensors_intf_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensors_intf_mem_arbiter
// Description : Directed self-checking bench for sensors_intf_mem_arbiter,
//               with a behavioural 1-cycle-latency byte-enabled RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensors_intf_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] a_address, b_address, mem_address;
    logic [3:0]  a_byteenable, b_byteenable, mem_byteenable;
    logic        a_read, a_write, b_read, b_write;
    logic [31:0] a_writedata, b_writedata, mem_writedata, mem_readdata;
    logic        a_waitrequest, b_waitrequest;
    logic [31:0] a_readdata, b_readdata;
    logic        a_readdatavalid, b_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken;

    int n_err    = 0;
    int n_checks = 0;

    logic [31:0] tb_mem [0:16383];
    logic [9:0]  exp_ga;

    sensors_intf_mem_arbiter #(
        .ADDR_W    (14),
        .DEPTH     (10500),
        .MAX_BURST (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .a_address       (a_address),
        .a_byteenable    (a_byteenable),
        .a_read          (a_read),
        .a_write         (a_write),
        .a_writedata     (a_writedata),
        .a_waitrequest   (a_waitrequest),
        .a_readdata      (a_readdata),
        .a_readdatavalid (a_readdatavalid),
        .b_address       (b_address),
        .b_byteenable    (b_byteenable),
        .b_read          (b_read),
        .b_write         (b_write),
        .b_writedata     (b_writedata),
        .b_waitrequest   (b_waitrequest),
        .b_readdata      (b_readdata),
        .b_readdatavalid (b_readdatavalid),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_clken       (mem_clken),
        .mem_readdata    (mem_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: registered read, byte-lane writes.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16384; i++) tb_mem[i] <= 32'h0;
        end else if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int j = 0; j < 4; j++)
                    if (mem_byteenable[j]) tb_mem[mem_address][8*j +: 8] <= mem_writedata[8*j +: 8];
            end
            mem_readdata <= tb_mem[mem_address];
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drv_a(input logic rd, input logic wr, input logic [13:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        a_read = rd; a_write = wr; a_address = addr; a_writedata = wd; a_byteenable = be;
    endtask

    task automatic drv_b(input logic rd, input logic wr, input logic [13:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        b_read = rd; b_write = wr; b_address = addr; b_writedata = wd; b_byteenable = be;
    endtask

    task automatic idle();
        drv_a(1'b0, 1'b0, 14'd0, 32'h0, 4'h0);
        drv_b(1'b0, 1'b0, 14'd0, 32'h0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        drv_a(1'b1, 1'b0, 14'd5, 32'h0, 4'hF);
        exp_ga = 10'b11_0000_1111;

        // Reset behaviour
        settle();
        chk1 ("rst_a_wait",  a_waitrequest,   1'b1);
        chk1 ("rst_cs",      mem_chipselect,  1'b0);
        chk1 ("rst_we",      mem_write,       1'b0);
        chk1 ("rst_clken",   mem_clken,       1'b0);
        chk1 ("rst_a_rdv",   a_readdatavalid, 1'b0);
        chk1 ("rst_b_rdv",   b_readdatavalid, 1'b0);
        chk32("rst_a_rdata", a_readdata,      32'h0);
        next_cycle();
        next_cycle();

        // A write then read of address 5
        reset = 1'b0;
        drv_a(1'b0, 1'b1, 14'd5, 32'hDEADBEEF, 4'hF);
        settle();
        chk1 ("wr_a_wait", a_waitrequest, 1'b0);
        chk1 ("wr_cs",     mem_chipselect, 1'b1);
        chk1 ("wr_we",     mem_write,      1'b1);
        chk1 ("wr_clken",  mem_clken,      1'b1);
        chk32("wr_wdata",  mem_writedata,  32'hDEADBEEF);
        chk32("wr_addr",   {18'h0, mem_address}, 32'd5);
        next_cycle();
        drv_a(1'b1, 1'b0, 14'd5, 32'h0, 4'hF);
        settle();
        chk1 ("rd_a_wait", a_waitrequest, 1'b0);
        chk1 ("rd_cs",     mem_chipselect, 1'b1);
        chk1 ("rd_we",     mem_write,      1'b0);
        next_cycle();
        idle();
        settle();
        chk1 ("rd_a_rdv",   a_readdatavalid, 1'b1);
        chk32("rd_a_rdata", a_readdata,      32'hDEADBEEF);
        chk1 ("rd_b_rdv",   b_readdatavalid, 1'b0);
        next_cycle();
        settle();
        chk1 ("rd_a_rdv_once", a_readdatavalid, 1'b0);

        // Byte-lane write
        drv_a(1'b0, 1'b1, 14'd7, 32'h11223344, 4'hF);
        next_cycle();
        drv_a(1'b0, 1'b1, 14'd7, 32'hAABBCCDD, 4'b0101);
        next_cycle();
        drv_a(1'b1, 1'b0, 14'd7, 32'h0, 4'hF);
        next_cycle();
        idle();
        settle();
        chk1 ("be_rdv",   a_readdatavalid, 1'b1);
        chk32("be_rdata", a_readdata,      32'h11BB33DD);

        // Simultaneous read and write from A is a write
        next_cycle();
        drv_a(1'b1, 1'b1, 14'd3, 32'h00000033, 4'hF);
        settle();
        chk1 ("rw_we",     mem_write,     1'b1);
        chk1 ("rw_a_wait", a_waitrequest, 1'b0);
        next_cycle();
        idle();
        settle();
        chk1 ("rw_no_rdv", a_readdatavalid, 1'b0);
        next_cycle();
        drv_a(1'b1, 1'b0, 14'd3, 32'h0, 4'hF);
        next_cycle();
        idle();
        settle();
        chk1 ("rw_rb_rdv",   a_readdatavalid, 1'b1);
        chk32("rw_rb_rdata", a_readdata,      32'h00000033);
        next_cycle();

        // Contention: A owns with run=0, expect A A A A B B B B A A
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            drv_a(1'b1, 1'b0, 14'd5, 32'h0, 4'hF);
            drv_b(1'b1, 1'b0, 14'd7, 32'h0, 4'hF);
            settle();
            chk1($sformatf("rr_a_wait_%0d", i), a_waitrequest, ~exp_ga[i]);
            chk1($sformatf("rr_b_wait_%0d", i), b_waitrequest,  exp_ga[i]);
            if (i > 0) begin
                chk1($sformatf("rr_a_rdv_%0d", i), a_readdatavalid,  exp_ga[i-1]);
                chk1($sformatf("rr_b_rdv_%0d", i), b_readdatavalid, ~exp_ga[i-1]);
                if (exp_ga[i-1]) chk32($sformatf("rr_a_rdata_%0d", i), a_readdata, 32'hDEADBEEF);
                else             chk32($sformatf("rr_b_rdata_%0d", i), b_readdata, 32'h11BB33DD);
            end
        end
        next_cycle();
        idle();
        settle();
        chk1 ("rr_last_a_rdv", a_readdatavalid, 1'b1);
        chk1 ("rr_last_b_rdv", b_readdatavalid, 1'b0);

        // Out-of-range accesses from B
        next_cycle();
        drv_b(1'b0, 1'b1, 14'd10500, 32'h12345678, 4'hF);
        settle();
        chk1 ("oor_wr_wait", b_waitrequest,  1'b0);
        chk1 ("oor_wr_cs",   mem_chipselect, 1'b0);
        chk1 ("oor_wr_we",   mem_write,      1'b0);
        next_cycle();
        drv_b(1'b1, 1'b0, 14'd10500, 32'h0, 4'hF);
        settle();
        chk1 ("oor_rd1_cs",   mem_chipselect, 1'b0);
        chk1 ("oor_rd1_wait", b_waitrequest,  1'b0);
        next_cycle();
        drv_b(1'b1, 1'b0, 14'd16383, 32'h0, 4'hF);
        settle();
        chk1 ("oor_rd2_cs",    mem_chipselect,  1'b0);
        chk1 ("oor_rd1_rdv",   b_readdatavalid, 1'b1);
        chk32("oor_rd1_rdata", b_readdata,      32'h0);
        next_cycle();
        drv_b(1'b1, 1'b0, 14'd10499, 32'h0, 4'hF);
        settle();
        chk1 ("oor_rd2_rdv",   b_readdatavalid, 1'b1);
        chk32("oor_rd2_rdata", b_readdata,      32'h0);
        chk1 ("last_word_cs",  mem_chipselect,  1'b1);
        chk32("oor_mem_kept",  tb_mem[10500],   32'h0);
        next_cycle();
        idle();
        settle();
        chk1 ("last_word_rdv", b_readdatavalid, 1'b1);

        // Reset in the cycle after a B read accept
        next_cycle();
        drv_b(1'b1, 1'b0, 14'd7, 32'h0, 4'hF);
        settle();
        chk1 ("rr6_b_wait", b_waitrequest, 1'b0);
        next_cycle();
        reset = 1'b1;
        idle();
        settle();
        chk1 ("rr6_b_rdv",   b_readdatavalid, 1'b0);
        chk32("rr6_b_rdata", b_readdata,      32'h0);
        chk1 ("rr6_clken",   mem_clken,       1'b0);
        next_cycle();
        reset = 1'b0;
        drv_a(1'b1, 1'b0, 14'd5, 32'h0, 4'hF);
        drv_b(1'b1, 1'b0, 14'd7, 32'h0, 4'hF);
        settle();
        chk1 ("post_rst_a_wait", a_waitrequest, 1'b0);
        chk1 ("post_rst_b_wait", b_waitrequest, 1'b1);
        next_cycle();
        idle();
        settle();
        chk1 ("post_rst_a_rdv", a_readdatavalid, 1'b1);
        chk1 ("post_rst_b_rdv", b_readdatavalid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensors_intf_mem_arbiter.md
# sensors_intf_mem_arbiter

Two-port Avalon-MM arbiter that shares the single-port 32-bit sensor-interface on-chip memory (14-bit word address, 10500 words, 1-cycle read latency) between two masters. Port A is the Nios CPU data master. Port B is the sensor capture/DMA engine. The block sits between both masters and the memory's s1 slave. It issues at most one access per cycle and uses a bounded-burst round-robin policy. It routes read data back to the correct master and absorbs out-of-range accesses so they never reach the RAM.

## Interface
Parameters:
- ADDR_W, 14: word-address width of both ports and the memory.
- DEPTH, 10500: number of valid memory words. Addresses >= DEPTH are out of range.
- MAX_BURST, 4: maximum consecutive grants to one port while the other port is requesting. Legal range is 1..255.

Ports:
- clk, in, 1: single clock for the block and the memory.
- reset, in, 1: synchronous, active-high.
- a_address, in, ADDR_W: port A word address.
- a_byteenable, in, 4: port A byte lanes.
- a_read, in, 1: port A read request.
- a_write, in, 1: port A write request.
- a_writedata, in, 32: port A write data.
- a_waitrequest, out, 1: port A request not accepted this cycle.
- a_readdata, out, 32: port A read data.
- a_readdatavalid, out, 1: a_readdata is valid this cycle.
- b_address, b_byteenable, b_read, b_write, b_writedata, b_waitrequest, b_readdata, b_readdatavalid: port B, identical to port A.
- mem_address, out, ADDR_W: memory address.
- mem_byteenable, out, 4: memory byte enables.
- mem_chipselect, out, 1: memory chipselect.
- mem_write, out, 1: memory write.
- mem_writedata, out, 32: memory write data.
- mem_clken, out, 1: memory clock enable.
- mem_readdata, in, 32: memory read data, valid one cycle after the address is presented.

## Operation
- Request per port: req_x = x_read | x_write. If a master asserts read and write together, the access is treated as a write and no read data is returned.
- Arbitration state:
  - owner: the last port granted (A or B).
  - run: 8-bit count of consecutive grants to owner.
  - Reset values: owner = A, run = 0.
- Winner selection, combinational, each cycle:
  - Neither port requesting: no grant. run <= 0; owner unchanged.
  - One port requesting: that port wins.
  - Both requesting and run < MAX_BURST: owner wins.
  - Both requesting and run >= MAX_BURST: the other port wins.
- Grant update: if the winner equals owner, run <= run + 1, saturating at 255. Otherwise owner <= winner and run <= 1.
- x_waitrequest = req_x & ~grant_x. With no request, waitrequest is 0.
- Memory drive:
  - mem_address, mem_byteenable and mem_writedata are a combinational mux of the winning port. With no grant they are 0.
  - mem_chipselect = grant & (address < DEPTH).
  - mem_write = mem_chipselect & winner write.
- Out-of-range access (address >= DEPTH):
  - Accepted in one cycle with no memory access.
  - A write is discarded.
  - A read returns 32'h0 with normal readdatavalid timing.
- Read return registers: rd_a, rd_b and rd_oor are set on the cycle a read is accepted. Next cycle:
  - x_readdatavalid = rd_x.
  - x_readdata = rd_x ? (rd_oor ? 0 : mem_readdata) : 0.
- mem_clken = ~reset.
- During reset:
  - Grants are forced to 0, so waitrequest = req.
  - rd_a, rd_b and rd_oor are cleared.
  - All memory control outputs are 0.

## Timing
- Output values during and after reset: all waitrequest = req (combinational), readdatavalid = 0, readdata = 0, mem_chipselect = 0, mem_write = 0, mem_clken = 0 during reset and 1 after.
- Accept latency:
  - Uncontended request: accepted in the same cycle.
  - Contended request: worst-case wait is MAX_BURST cycles.
- Read latency: read accepted in cycle N gives readdatavalid in cycle N+1. Exactly one valid pulse per accepted read, and never to the non-winning port.
- Throughput: one access per cycle. Back-to-back reads from alternating ports return in acceptance order.
- Write takes effect at the clock edge ending the accept cycle. A read of the same address in the next cycle returns the new data.
- Reset asserted in the cycle after a read accept suppresses that readdatavalid.
- No combinational path from mem_readdata to any waitrequest.

## Test plan
- Reset, then A writes 32'hDEADBEEF to address 5 with byteenable 4'hF, then A reads address 5. Required: no wait on either access; a_readdatavalid one cycle after the read accept with data 32'hDEADBEEF; b_readdatavalid stays 0.
- A and B both issue continuous reads with MAX_BURST = 4. Required grant sequence: A A A A B B B B A ..., with every waitrequest pulse matching a lost cycle.
- Byte-lane write: write 32'h11223344 to address 7, then write 32'hAABBCCDD with byteenable 4'b0101, then read address 7. Required read data: 32'h11BB33DD.
- Out of range: B writes 32'h12345678 to address 10500, then B reads addresses 10500 and 16383. Required: mem_chipselect stays 0 throughout; each read returns 0 with readdatavalid at N+1; memory contents unchanged.
- Simultaneous read and write from A to address 3. Required: treated as a write, with no a_readdatavalid pulse.
- Reset asserted in the cycle after a B read accept. Required: no b_readdatavalid pulse; after reset, the next contended cycle is granted to A.
